// File: rtl/disp_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display.
// Steps the digit select, opens each slot with a blanking interval, and drives active-low anodes.
module disp_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] digit_en,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic       scan_tick,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    sel_next;
    logic          tick_next;
    logic          frame_next;
    logic [7:0]    an_next;
    logic          on_c;

    // Slot counter and digit advance
    always_comb begin
        cnt_next   = cnt;
        sel_next   = sel;
        tick_next  = 1'b0;
        frame_next = 1'b0;
        if (en) begin
            if (cnt == LAST) begin
                cnt_next   = '0;
                sel_next   = sel + 3'd1;
                tick_next  = 1'b1;
                frame_next = (sel == 3'd7);
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // ON phase of the slot the registers are about to enter
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign on_c = 1'b1;
        end else begin : g_blank
            assign on_c = (cnt_next >= CW'(BLANK_CYCLES));
        end
    endgenerate

    // Anodes follow next-state so they line up with the sel presented in the same cycle
    always_comb begin
        an_next = 8'hFF;
        if (en && on_c && digit_en[sel_next]) begin
            an_next = ~(8'b1 << sel_next);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sel        <= 3'd0;
            an         <= 8'hFF;
            scan_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            sel        <= sel_next;
            an         <= an_next;
            scan_tick  <= tick_next;
            frame_done <= frame_next;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: vector table for reset/first slots, then directed sequences.
module tb_disp_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] digit_en;
    logic [2:0] sel;
    logic [7:0] an;
    logic       scan_tick;
    logic       frame_done;

    logic [7:0] digit_en_nb;
    logic [2:0] sel_nb;
    logic [7:0] an_nb;
    logic       tick_nb;
    logic       frame_nb;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .en(en), .digit_en(digit_en),
        .sel(sel), .an(an), .scan_tick(scan_tick), .frame_done(frame_done)
    );

    disp_scan_ctrl #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) u_nb (
        .clk(clk), .reset(reset), .en(en), .digit_en(digit_en_nb),
        .sel(sel_nb), .an(an_nb), .scan_tick(tick_nb), .frame_done(frame_nb)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] de;
        logic [2:0] sel;
        logic [7:0] an;
        logic       tick;
        logic       frame;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] on_an [8];
    int checks = 0;
    int errors = 0;
    int m_cnt, m_sel, n_tick, n_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Expected effect of one edge with the currently driven inputs
    task automatic model_edge(output logic t, output logic f);
        t = 1'b0;
        f = 1'b0;
        if (reset) begin
            m_cnt = 0;
            m_sel = 0;
        end else if (en) begin
            if (m_cnt == 7) begin
                m_cnt = 0;
                f = (m_sel == 7);
                m_sel = (m_sel + 1) % 8;
                t = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic run(input int n, input string name);
        logic t, f;
        logic [7:0] ea;
        for (int i = 0; i < n; i++) begin
            model_edge(t, f);
            ea = (!reset && en && m_cnt >= 2 && digit_en[m_sel]) ? on_an[m_sel] : 8'hFF;
            tick_clk();
            check({name, "_sel"},   32'(sel),        32'(m_sel));
            check({name, "_an"},    32'(an),         32'(ea));
            check({name, "_tick"},  32'(scan_tick),  32'(t));
            check({name, "_frame"}, 32'(frame_done), 32'(f));
            n_tick  += int'(t);
            n_frame += int'(f);
        end
    endtask

    task automatic run_until(input int c, input int s, input string name);
        int guard = 0;
        while (!(m_cnt == c && m_sel == s) && guard < 200) begin
            run(1, name);
            guard++;
        end
        check({name, "_reach_sel"}, 32'(sel), 32'(s));
    endtask

    initial begin
        on_an[0] = 8'hFE; on_an[1] = 8'hFD; on_an[2] = 8'hFB; on_an[3] = 8'hF7;
        on_an[4] = 8'hEF; on_an[5] = 8'hDF; on_an[6] = 8'hBF; on_an[7] = 8'h7F;

        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 3'd1, 8'hFF, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hFF, 3'd1, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'hFF, 3'd1, 8'hFD, 1'b0, 1'b0};

        reset = 1'b1;
        en = 1'b0;
        digit_en = 8'hFF;
        digit_en_nb = 8'hFF;

        for (int v = 0; v < 13; v++) begin
            reset = vecs[v].rst;
            en = vecs[v].en;
            digit_en = vecs[v].de;
            tick_clk();
            check($sformatf("vec%0d_sel", v),   32'(sel),        32'(vecs[v].sel));
            check($sformatf("vec%0d_an", v),    32'(an),         32'(vecs[v].an));
            check($sformatf("vec%0d_tick", v),  32'(scan_tick),  32'(vecs[v].tick));
            check($sformatf("vec%0d_frame", v), 32'(frame_done), 32'(vecs[v].frame));
        end

        // Rest of the first frame: 64 edges after release in total
        m_cnt = 2; m_sel = 1; n_tick = 1; n_frame = 0;
        run(54, "frame");
        check("frame_tick_count", 32'(n_tick), 32'd8);
        check("frame_done_count", 32'(n_frame), 32'd1);
        check("frame_wrap_sel", 32'(sel), 32'd0);

        digit_en = 8'h0F;
        run(64, "mask");

        digit_en = 8'hFF;
        run_until(5, 3, "to_freeze");
        en = 1'b0;
        n_tick = 0; n_frame = 0;
        run(10, "freeze");
        check("freeze_strobes", 32'(n_tick + n_frame), 32'd0);
        en = 1'b1;
        run(1, "resume");
        check("resume_an", 32'(an), 32'hF7);
        run(2, "resume2");
        check("resume_sel4", 32'(sel), 32'd4);
        check("resume_tick", 32'(scan_tick), 32'd1);

        run_until(6, 5, "to_rst");
        reset = 1'b1;
        run(1, "rst_mid");
        check("rst_mid_sel", 32'(sel), 32'd0);
        check("rst_mid_frame", 32'(frame_done), 32'd0);
        reset = 1'b0;
        run(17, "restart");

        // No-blank instance: restart both from reset
        reset = 1'b1;
        run(2, "rst2");
        check("nb_rst_an", 32'(an_nb), 32'hFF);
        check("nb_rst_sel", 32'(sel_nb), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            run(1, "nb_main");
            check($sformatf("nb_lit_%0d", k),   32'(an_nb == 8'hFF), 32'd0);
            check($sformatf("nb_sel_%0d", k),   32'(sel_nb), 32'((k / 2) % 8));
            check($sformatf("nb_frame_%0d", k), 32'(frame_nb), 32'(k % 16 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It steps the 3-bit digit select that drives the 8:1 nibble mux feeding the segment decoder, and drives the matching active-low anode line. Each digit gets a fixed-length slot that opens with a blanking interval to suppress ghosting. Per-digit enables, a scan enable, and per-slot and per-frame strobes are provided for downstream logic.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot, including the blanking interval; must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; legal range 0 to REFRESH_DIV-1.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; dominates every other input.
- en  input  1  scan enable; 0 freezes the scan and blanks the display.
- digit_en  input  8  per-digit light enable; bit i corresponds to digit i.
- sel  output  3  current digit index; drives the mux select.
- an  output  8  anodes, active-low; at most one bit is 0 at any time.
- scan_tick  output  1  one-cycle pulse in the first cycle of each new slot.
- frame_done  output  1  one-cycle pulse in the first cycle of slot 0 after a wrap from 7.

## Operation
- Internal slot counter cnt has width $clog2(REFRESH_DIV) and counts 0..REFRESH_DIV-1.
- Each slot has two phases, decoded from cnt:
  - BLANK: cnt < BLANK_CYCLES.
  - ON: cnt ≥ BLANK_CYCLES.
- Edge with en=1 and cnt < REFRESH_DIV-1: cnt increments; sel holds.
- Edge with en=1 and cnt = REFRESH_DIV-1:
  - cnt goes to 0.
  - sel advances to (sel+1) mod 8; 7 wraps to 0.
  - scan_tick goes to 1.
  - frame_done goes to 1 only if the old sel was 7.
- Edge with en=0: cnt and sel hold; scan_tick=0; frame_done=0; an=8'hFF.
- an is registered from next-state values:
  - an = ~(8'b1 << sel_next) when en=1, cnt_next ≥ BLANK_CYCLES, and digit_en[sel_next]=1.
  - an = 8'hFF in every other case.
- Consequence: in any cycle, an is consistent with the sel and cnt presented in that same cycle.
- A masked digit (digit_en[i]=0) keeps its full slot time with an=FF. The scan never skips digits, so refresh rate is independent of the mask.
- BLANK_CYCLES=0: there is no blank phase, and an changes directly from one digit to the next.

## Timing
- Reset values: sel=0, an=8'hFF, scan_tick=0, frame_done=0, internal cnt=0.
- Reset asserted mid-frame: the next cycle shows the reset values. No frame_done or scan_tick is generated by the reset.
- First cycle after reset release with en=1: cnt=0. The scan starts at digit 0, BLANK phase. scan_tick is not asserted for this initial slot.
- Slot length: exactly REFRESH_DIV cycles. Frame length: 8·REFRESH_DIV cycles.
- scan_tick: high exactly in cycles where cnt=0 as a result of a wrap (not a reset), with en=1 on the causing edge.
- frame_done: coincides with the scan_tick that accompanies sel=0.
- digit_en: sampled on each edge; a change affects an one cycle later.
- en falling: an=FF from the next cycle. Counting resumes from the held cnt on the first edge with en=1. No slot is restarted or shortened.
- Strobes are never asserted while en=0 or reset=1.

## Test plan
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2 unless stated.
- Reset then run: reset=1 for 3 cycles → sel=0, an=FF, strobes 0. Release with en=1, digit_en=FF → an=FF for 2 cycles, an=8'hFE for 6 cycles, then sel=1, scan_tick=1, an=FF.
- Full frame: 64 cycles after release → sel steps 0..7. ON-phase an values are FE, FD, FB, F7, EF, DF, BF, 7F. Exactly 8 scan_tick pulses; one frame_done, coincident with sel returning to 0.
- Mask: digit_en=8'h0F → an=FF throughout the slots for sel=4..7; sel timing unchanged; digits 0–3 behave normally.
- Freeze: drop en at cnt=5, sel=3, for 10 cycles → an=FF and sel=3 throughout, no strobes. Re-assert en → an=8'hF7 on the next cycle. sel advances to 4 after 3 further cycles.
- Reset mid-frame: assert reset at sel=5, cnt=6 → next cycle sel=0, an=FF, no frame_done. The scan restarts cleanly after release.
- No blanking: REFRESH_DIV=2, BLANK_CYCLES=0, digit_en=FF → an never FF after the first post-reset cycle; sel changes every 2 cycles; frame_done every 16 cycles.
